fetch_sequencer: RTL

- Instruction-fetch controller that owns the program counter and sequences instruction-cache reads.
- Resolves BEQ/BNE/JUMP redirects from the execute stage.
- Holds the fetched instruction until the decode stage accepts it.
- Sits between the instruction cache and decode; replaces free-running PC update with a handshake-driven one.

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_sequencer_branch_resolve.sv | 46 ++++
 rtl/fetch_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional feature macro: FETCH_PERF_CNT_EN (performance counters in the top).
package fetch_sequencer_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StReq   = 2'b01,
        StWait  = 2'b10,
        StValid = 2'b11
    } fetch_state_e;

    // Execute-stage branch encodings; 2'b11 is reserved and never taken
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    // Default configuration
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_STEP      = 4;
    localparam int unsigned DEFAULT_OFFSET_W     = 8;

endpackage

// File: rtl/fetch_sequencer_branch_resolve.sv
// Combinational branch resolution: decides whether the control instruction
// presented by execute redirects fetch, and computes the redirect target.
module fetch_sequencer_branch_resolve
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned OFFSET_W = DEFAULT_OFFSET_W
) (
    input  logic                br_valid_i,
    input  logic [31:0]         br_pc_i,
    input  logic [1:0]          branch_i,
    input  logic                jump_i,
    input  logic                zero_i,
    input  logic [OFFSET_W-1:0] branch_offset_i,
    output logic                taken_o,
    output logic [31:0]         target_o
);

    logic [31:0] offset_ext;
    logic        unused_br_pc_lsb;

    // The low PC bits are forced to a word boundary, so they never matter
    assign unused_br_pc_lsb = ^br_pc_i[1:0];

    // Word offset, sign-extended and scaled to bytes
    assign offset_ext = {{(30 - OFFSET_W){branch_offset_i[OFFSET_W-1]}}, branch_offset_i, 2'b00};

    // Target relative to the instruction following the branch, modulo 2^32
    assign target_o = {br_pc_i[31:2], 2'b00} + 32'd4 + offset_ext;

    // Taken decision: jump wins, otherwise condition on the zero flag
    always_comb begin
        taken_o = 1'b0;
        if (br_valid_i) begin
            if (jump_i) begin
                taken_o = 1'b1;
            end else begin
                case (branch_i)
                    BR_BEQ:  taken_o = zero_i;
                    BR_BNE:  taken_o = ~zero_i;
                    default: taken_o = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues instruction-cache reads,
// holds the fetched instruction until decode accepts it, and applies
// execute-stage redirects. Redirects arriving while a read is outstanding are
// parked until that read completes, then the returned data is dropped.
// Optional feature macro: FETCH_PERF_CNT_EN adds STALL_CYCLES/REDIRECT_COUNT.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned PC_STEP      = DEFAULT_PC_STEP,
    parameter int unsigned OFFSET_W     = DEFAULT_OFFSET_W
) (
    input  logic                CLK,
    input  logic                RESET,
    output logic                IC_READ,
    output logic [31:0]         IC_ADDR,
    input  logic [31:0]         IC_INSTR,
    input  logic                IC_BUSYWAIT,
    output logic [31:0]         INSTR,
    output logic                INSTR_VALID,
    input  logic                STALL,
    output logic [31:0]         PC_OUT,
    input  logic                BR_VALID,
    input  logic [31:0]         BR_PC,
    input  logic [1:0]          BRANCH,
    input  logic                JUMP,
    input  logic                ZERO,
    input  logic [OFFSET_W-1:0] BRANCH_OFFSET
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         STALL_CYCLES,
    output logic [15:0]         REDIRECT_COUNT
`endif
);

    localparam logic [31:0] PcStep = 32'(PC_STEP);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         ic_read_q, ic_read_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_target_q, pend_target_d;

    logic         br_taken;
    logic [31:0]  br_target;

    fetch_sequencer_branch_resolve #(
        .OFFSET_W (OFFSET_W)
    ) u_branch_resolve (
        .br_valid_i      (BR_VALID),
        .br_pc_i         (BR_PC),
        .branch_i        (BRANCH),
        .jump_i          (JUMP),
        .zero_i          (ZERO),
        .branch_offset_i (BRANCH_OFFSET),
        .taken_o         (br_taken),
        .target_o        (br_target)
    );

    // Next-state, PC, instruction capture and pending-redirect bookkeeping
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;

        case (state_q)
            // Redirects are ignored until the first request goes out
            StIdle: begin
                state_d = StReq;
            end

            StReq: begin
                state_d = StWait;
                if (br_taken) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = br_target;
                end
            end

            StWait: begin
                if (IC_BUSYWAIT) begin
                    // Newest taken redirect overwrites any older parked one
                    if (br_taken) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = br_target;
                    end
                end else if (br_taken) begin
                    pc_d         = br_target;
                    pend_valid_d = 1'b0;
                    state_d      = StReq;
                end else if (pend_valid_q) begin
                    pc_d         = pend_target_q;
                    pend_valid_d = 1'b0;
                    state_d      = StReq;
                end else begin
                    instr_d       = IC_INSTR;
                    instr_valid_d = 1'b1;
                    state_d       = StValid;
                end
            end

            StValid: begin
                // A redirect flushes the held instruction even under stall
                if (br_taken) begin
                    pc_d          = br_target;
                    instr_valid_d = 1'b0;
                    state_d       = StReq;
                end else if (!STALL) begin
                    pc_d          = pc_q + PcStep;
                    instr_valid_d = 1'b0;
                    state_d       = StReq;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Read request registered from the state being entered
        ic_read_d = (state_d == StReq) || (state_d == StWait);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q       <= StIdle;
            pc_q          <= RESET_VECTOR;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            ic_read_q     <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            ic_read_q     <= ic_read_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign IC_READ     = ic_read_q;
    assign IC_ADDR     = pc_q;
    assign PC_OUT      = pc_q;
    assign INSTR       = instr_q;
    assign INSTR_VALID = instr_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] redirect_count_q, redirect_count_d;
    logic        stall_event;
    logic        redirect_event;

    // Cycles lost to cache misses or to decode back-pressure
    assign stall_event = ((state_q == StWait) && IC_BUSYWAIT) ||
                         ((state_q == StValid) && STALL);

    // Taken redirects accepted by the sequencer (IDLE drops them)
    assign redirect_event = br_taken && (state_q != StIdle);

    // Saturating counter increments
    always_comb begin
        stall_cycles_d   = stall_cycles_q;
        redirect_count_d = redirect_count_q;
        if (stall_event && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (redirect_event && (redirect_count_q != '1)) begin
            redirect_count_d = redirect_count_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            stall_cycles_q   <= 32'h0;
            redirect_count_q <= 16'h0;
        end else begin
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign STALL_CYCLES   = stall_cycles_q;
    assign REDIRECT_COUNT = redirect_count_q;
`endif

endmodule
